// File: rtl/audio_pkt_fifo_ctrl.sv
// Single-clock FIFO controller around an external SDPRAM: pointer/level bookkeeping on the write
// side, and a burst read FSM that streams PKT_LEN words framed by sop/eop once enough are buffered.
module audio_pkt_fifo_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_REG    = 0,
    parameter int PKT_LEN    = 256,
    parameter int AFULL_TH   = 960
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_vld,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  afull,
    output logic                  ovf,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  pkt_rdy,
    input  logic                  pkt_req,
    output logic                  busy,
    output logic                  dout_vld,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_sop,
    output logic                  dout_eop
);

    localparam int STAGES = OUT_REG;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_L  = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0]   PKT_L    = (ADDR_WIDTH+1)'(PKT_LEN);
    localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(PKT_LEN - 1);
    // Tags still in flight that have not yet reached the output stage.
    localparam logic [STAGES:0]       PEND_MASK = (STAGES+1)'((1 << STAGES) - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  wr_acc, issue, pend, cap;
    logic [STAGES:0]       vld_pipe, sop_pipe, eop_pipe;

    assign level       = wr_ptr - rd_ptr;
    assign full        = (level == DEPTH_L);
    assign afull       = (level >= AFULL_L);

    assign wr_acc      = din_vld & ~full;
    assign ram_wr_en   = wr_acc;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = din;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    assign issue       = (state == READ);
    assign wr_ptr_nxt  = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
    assign rd_ptr_nxt  = rd_ptr + {{ADDR_WIDTH{1'b0}}, issue};
    assign level_nxt   = wr_ptr_nxt - rd_ptr_nxt;

    assign pend        = |(vld_pipe & PEND_MASK);
    // Async RAM data is valid in the issue cycle; a registered RAM delivers it one cycle later.
    assign cap         = (OUT_REG == 0) ? issue : pend;

    assign dout_vld    = vld_pipe[STAGES];
    assign dout_sop    = sop_pipe[STAGES];
    assign dout_eop    = eop_pipe[STAGES];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pkt_req && pkt_rdy) begin
                    state_nxt = READ;
                    cnt_nxt   = '0;
                end
            end
            READ: begin
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt == LAST_CNT) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!pend) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (din_vld && full) ovf <= 1'b1;
        end
    end

    // Flags follow the next state so they line up exactly with state/level after each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_rdy <= 1'b0;
            busy    <= 1'b0;
        end else begin
            pkt_rdy <= (state_nxt == IDLE) && (level_nxt >= PKT_L);
            busy    <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sop_pipe <= '0;
            eop_pipe <= '0;
            dout     <= '0;
        end else begin
            vld_pipe[0] <= issue;
            sop_pipe[0] <= issue && (cnt == '0);
            eop_pipe[0] <= issue && (cnt == LAST_CNT);
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sop_pipe[i] <= sop_pipe[i-1];
                eop_pipe[i] <= eop_pipe[i-1];
            end
            if (cap) dout <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_audio_pkt_fifo_ctrl.sv
// Scoreboard bench: two instances (async-read/256-word bursts and registered-read/1-word bursts)
// with external RAM models; monitors pop expected beats as dout_vld appears.
module tb_audio_pkt_fifo_ctrl;
    localparam int DW = 16;
    localparam int PKT0 = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance 0: ADDR_WIDTH=10, OUT_REG=0, PKT_LEN=256
    logic          din_vld0, pkt_req0, full0, afull0, ovf0, wr_en0, pkt_rdy0, busy0;
    logic          dout_vld0, sop0, eop0;
    logic [DW-1:0] din0, wr_data0, rd_data0, dout0;
    logic [10:0]   level0;
    logic [9:0]    wr_addr0, rd_addr0;
    // instance 1: ADDR_WIDTH=3, OUT_REG=1, PKT_LEN=1
    logic          din_vld1, pkt_req1, full1, afull1, ovf1, wr_en1, pkt_rdy1, busy1;
    logic          dout_vld1, sop1, eop1;
    logic [DW-1:0] din1, wr_data1, rd_data1, dout1, rd_q1;
    logic [3:0]    level1;
    logic [2:0]    wr_addr1, rd_addr1;

    audio_pkt_fifo_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(DW), .OUT_REG(0), .PKT_LEN(PKT0), .AFULL_TH(960)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .din_vld(din_vld0), .din(din0), .full(full0), .afull(afull0),
        .ovf(ovf0), .level(level0), .ram_wr_en(wr_en0), .ram_wr_addr(wr_addr0), .ram_wr_data(wr_data0),
        .ram_rd_addr(rd_addr0), .ram_rd_data(rd_data0), .pkt_rdy(pkt_rdy0), .pkt_req(pkt_req0),
        .busy(busy0), .dout_vld(dout_vld0), .dout(dout0), .dout_sop(sop0), .dout_eop(eop0));

    audio_pkt_fifo_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(DW), .OUT_REG(1), .PKT_LEN(1), .AFULL_TH(6)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_vld(din_vld1), .din(din1), .full(full1), .afull(afull1),
        .ovf(ovf1), .level(level1), .ram_wr_en(wr_en1), .ram_wr_addr(wr_addr1), .ram_wr_data(wr_data1),
        .ram_rd_addr(rd_addr1), .ram_rd_data(rd_data1), .pkt_rdy(pkt_rdy1), .pkt_req(pkt_req1),
        .busy(busy1), .dout_vld(dout_vld1), .dout(dout1), .dout_sop(sop1), .dout_eop(eop1));

    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:7];
    always @(posedge clk) if (wr_en0) mem0[wr_addr0] <= wr_data0;
    assign rd_data0 = mem0[rd_addr0];
    always @(posedge clk) begin
        if (wr_en1) mem1[wr_addr1] <= wr_data1;
        rd_q1 <= mem1[rd_addr1];
    end
    assign rd_data1 = rd_q1;

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        int unsigned   c;
    } exp_t;

    exp_t          sb0[$];
    exp_t          sb1[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model1_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic          wr_on = 1'b0;
    logic [DW-1:0] wr_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dout_vld0) begin
            if (sb0.size() == 0) chk("dut0_unexpected_vld", dout_vld0, 0);
            else begin
                e = sb0.pop_front();
                chk("dut0_beat_cycle", cyc, e.c);
                chk("dut0_data", dout0, e.d);
                chk("dut0_sop", sop0, e.sop);
                chk("dut0_eop", eop0, e.eop);
            end
        end else if (sb0.size() != 0 && cyc > sb0[0].c) begin
            chk("dut0_missing_beat", dout_vld0, 1);
            void'(sb0.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dout_vld1) begin
            if (sb1.size() == 0) chk("dut1_unexpected_vld", dout_vld1, 0);
            else begin
                e = sb1.pop_front();
                chk("dut1_beat_cycle", cyc, e.c);
                chk("dut1_data", dout1, e.d);
                chk("dut1_sop", sop1, e.sop);
                chk("dut1_eop", eop1, e.eop);
            end
        end else if (sb1.size() != 0 && cyc > sb1[0].c) begin
            chk("dut1_missing_beat", dout_vld1, 1);
            void'(sb1.pop_front());
        end
    end

    task automatic tick();
        din_vld0 = wr_on;
        din0     = wr_data;
        @(posedge clk);
        if (wr_on) begin
            if (model_q.size() < 1024) model_q.push_back(wr_data);
            wr_data = wr_data + 1'b1;
        end
        #1;
    endtask

    task automatic req0();
        int unsigned k;
        exp_t e;
        k = cyc;
        pkt_req0 = 1'b1;
        for (int i = 0; i < PKT0; i++) begin
            e.d = model_q.pop_front();
            e.sop = (i == 0);
            e.eop = (i == PKT0 - 1);
            e.c = k + 2 + i;
            sb0.push_back(e);
        end
        tick();
        pkt_req0 = 1'b0;
    endtask

    task automatic wait_idle0(input int maxc);
        int n = 0;
        while (busy0 && n < maxc) begin tick(); n++; end
        chk("dut0_idle_timeout", busy0, 0);
    endtask

    task automatic drain_sb(input int maxc);
        int n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < maxc) begin tick(); n++; end
        chk("sb_drained", sb0.size() + sb1.size(), 0);
    endtask

    task automatic write1(input logic [DW-1:0] d);
        din_vld1 = 1'b1;
        din1 = d;
        tick();
        din_vld1 = 1'b0;
        model1_q.push_back(d);
    endtask

    task automatic req1();
        int unsigned k;
        exp_t e;
        k = cyc;
        pkt_req1 = 1'b1;
        e.d = model1_q.pop_front(); e.sop = 1'b1; e.eop = 1'b1; e.c = k + 3;
        sb1.push_back(e);
        tick();
        pkt_req1 = 1'b0;
        chk("dut1_busy_read", busy1, 1);
        chk("dut1_rdy_low", pkt_rdy1, 0);
        tick(); chk("dut1_busy_drain1", busy1, 1);
        tick(); chk("dut1_busy_drain2", busy1, 1);
        tick(); chk("dut1_busy_idle", busy1, 0);
    endtask

    initial begin
        din_vld0 = 1'b0; din0 = '0; pkt_req0 = 1'b0;
        din_vld1 = 1'b0; din1 = '0; pkt_req1 = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_level0", level0, 0);
        chk("rst_full0", full0, 0);
        chk("rst_afull0", afull0, 0);
        chk("rst_ovf0", ovf0, 0);
        chk("rst_rdy0", pkt_rdy0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_vld0", dout_vld0, 0);
        chk("rst_rdaddr0", rd_addr0, 0);
        chk("rst_level1", level1, 0);
        chk("rst_busy1", busy1, 0);
        rst_n = 1'b1;
        tick();

        // registered-read instance, single-word bursts
        write1(16'hA5A5);
        write1(16'h5A5A);
        chk("dut1_rdy", pkt_rdy1, 1);
        chk("dut1_level2", level1, 2);
        req1();
        req1();
        chk("dut1_level_end", level1, 0);
        chk("dut1_rdy_end", pkt_rdy1, 0);

        // 255 words: request ignored
        wr_on = 1'b1;
        repeat (255) tick();
        wr_on = 1'b0;
        chk("dut0_level255", level0, model_q.size());
        chk("dut0_rdy_at255", pkt_rdy0, 0);
        pkt_req0 = 1'b1; tick(); pkt_req0 = 1'b0;
        repeat (3) tick();
        chk("dut0_ignored_busy", busy0, 0);
        chk("dut0_ignored_level", level0, 255);
        chk("dut0_ignored_rdaddr", rd_addr0, 0);
        wr_on = 1'b1; tick(); wr_on = 1'b0;
        chk("dut0_rdy_at256", pkt_rdy0, 1);
        chk("dut0_level256", level0, 256);

        // first burst, with a request during READ that must be dropped
        req0();
        chk("dut0_busy_read", busy0, 1);
        chk("dut0_rdy_read", pkt_rdy0, 0);
        repeat (5) tick();
        chk("dut0_level_mid", level0, model_q.size() + 251);
        pkt_req0 = 1'b1; tick(); pkt_req0 = 1'b0;
        wait_idle0(400);
        chk("dut0_level_after", level0, 0);
        chk("dut0_rdy_after", pkt_rdy0, 0);
        repeat (3) tick();
        chk("dut0_no_requeue", busy0, 0);
        drain_sb(50);

        // fill to full, overflow, then free one burst
        wr_on = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (model_q.size() == 959) chk("dut0_afull_959", afull0, 0);
            if (model_q.size() == 960) chk("dut0_afull_960", afull0, 1);
            if (model_q.size() == 1023) chk("dut0_full_1023", full0, 0);
        end
        chk("dut0_full", full0, 1);
        chk("dut0_level_full", level0, 1024);
        chk("dut0_ovf_pre", ovf0, 0);
        tick();
        wr_on = 1'b0;
        chk("dut0_ovf", ovf0, 1);
        chk("dut0_level_ovf", level0, model_q.size());
        tick();
        chk("dut0_rdy_full", pkt_rdy0, 1);
        req0();
        wait_idle0(400);
        chk("dut0_full_freed", full0, 0);
        chk("dut0_level_768", level0, model_q.size());
        drain_sb(50);

        // bursts with continuous writes; write pointer wraps mid-stream
        wr_on = 1'b1;
        for (int b = 0; b < 3; b++) begin
            req0();
            for (int m = 1; m < PKT0; m++) begin
                tick();
                chk("dut0_level_const", level0, model_q.size() + PKT0 - m);
            end
            wait_idle0(50);
        end
        wr_on = 1'b0;
        tick();
        drain_sb(50);
        chk("dut0_level_wrap", level0, model_q.size());

        // async reset at beat 100
        chk("dut0_rdy_pre_rst", pkt_rdy0, 1);
        req0();
        repeat (101) tick();
        chk("dut0_beat100_live", dout_vld0, 1);
        sb0.delete();
        model_q.delete();
        rst_n = 1'b0;
        #1;
        chk("arst_vld", dout_vld0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_level", level0, 0);
        chk("arst_ovf", ovf0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy0, 0);
        chk("post_rst_rdy", pkt_rdy0, 0);
        chk("post_rst_level", level0, 0);
        chk("post_rst_vld", dout_vld0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
